// File: rtl/robot_wall_follower.sv
// Moore FSM for a left-hand wall-following robot: front/left obstacle sensors in, {front,turn} motor commands out.
// Optional build macro ROBOT_STATE_OUT_EN exposes the registered state code on state_o.
module robot_wall_follower #(
   parameter int CORNER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       front_sensor,
   input  logic       left_sensor,
   output logic       front,
   output logic       turn
`ifdef ROBOT_STATE_OUT_EN
   ,
   output logic [1:0] state_o
`endif
);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_ROTATE = 2'd1;
   localparam logic [1:0] ST_FOLLOW = 2'd2;
   localparam logic [1:0] ST_CORNER = 2'd3;

   localparam int              CNT_W   = $clog2(CORNER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CORNER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      // An obstacle ahead wins over everything else, from any state.
      if (front_sensor) begin
         state_d = ST_ROTATE;
      end else begin
         case (state_q)
            ST_SEARCH: state_d = left_sensor ? ST_FOLLOW : ST_SEARCH;
            ST_ROTATE: state_d = left_sensor ? ST_FOLLOW : ST_SEARCH;
            ST_FOLLOW: begin
               if (left_sensor) begin
                  state_d = ST_FOLLOW;
               end else begin
                  state_d = ST_CORNER;
                  cnt_d   = CNT_ONE;
               end
            end
            ST_CORNER: begin
               if (left_sensor) begin
                  state_d = ST_FOLLOW;
               end else if (cnt_q < CNT_MAX) begin
                  state_d = ST_CORNER;
                  cnt_d   = cnt_q + CNT_ONE;
               end else begin
                  state_d = ST_SEARCH;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SEARCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      front = 1'b1;
      turn  = 1'b0;
      case (state_q)
         ST_SEARCH: begin front = 1'b1; turn = 1'b0; end
         ST_ROTATE: begin front = 1'b0; turn = 1'b1; end
         ST_FOLLOW: begin front = 1'b1; turn = 1'b0; end
         ST_CORNER: begin front = 1'b1; turn = 1'b1; end
         default:   begin front = 1'b1; turn = 1'b0; end
      endcase
   end

`ifdef ROBOT_STATE_OUT_EN
   assign state_o = state_q;
`endif

endmodule

// File: tb/tb_robot_wall_follower.sv
// Bench for robot_wall_follower: directed scenarios followed by randomized sensor streams
// compared against a rule-level reference model.
module tb_robot_wall_follower;

   localparam int CC = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic front_sensor = 1'b0;
   logic left_sensor = 1'b0;
   logic front, turn;
`ifdef ROBOT_STATE_OUT_EN
   logic [1:0] state_o;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: behaviour name plus length of the current curving-left run
   typedef enum int {M_SEARCH, M_ROTATE, M_FOLLOW, M_CORNER} mode_t;
   mode_t mode = M_SEARCH;
   int    corner_run = 0;

   always #5 clk = ~clk;

   robot_wall_follower #(.CORNER_CYCLES(CC)) dut (
      .clk          (clk),
      .reset        (reset),
      .front_sensor (front_sensor),
      .left_sensor  (left_sensor),
      .front        (front),
      .turn         (turn)
`ifdef ROBOT_STATE_OUT_EN
      ,
      .state_o      (state_o)
`endif
   );

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%b required=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] motor_of(input mode_t m);
      case (m)
         M_ROTATE: return 2'b01;
         M_CORNER: return 2'b11;
         default:  return 2'b10;
      endcase
   endfunction

   function automatic logic [1:0] code_of(input mode_t m);
      case (m)
         M_ROTATE: return 2'd1;
         M_FOLLOW: return 2'd2;
         M_CORNER: return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

   // Advance the model by one clock edge from the robot's rules.
   task automatic model_edge(input logic r, input logic f, input logic l);
      if (r) begin
         mode = M_SEARCH; corner_run = 0;
      end else if (f) begin
         mode = M_ROTATE; corner_run = 0;
      end else if (l) begin
         mode = M_FOLLOW; corner_run = 0;
      end else if (mode == M_FOLLOW) begin
         mode = M_CORNER; corner_run = 1;
      end else if (mode == M_CORNER && corner_run < CC) begin
         corner_run = corner_run + 1;
      end else begin
         mode = M_SEARCH; corner_run = 0;
      end
   endtask

   task automatic step(input string tag, input logic r, input logic f, input logic l);
      @(negedge clk);
      reset = r; front_sensor = f; left_sensor = l;
      @(posedge clk);
      model_edge(r, f, l);
      #1;
      check(tag, {front, turn}, motor_of(mode));
`ifdef ROBOT_STATE_OUT_EN
      check({tag, "_state"}, state_o, code_of(mode));
`endif
   endtask

   initial begin
      int pl;
      step("reset", 1'b1, 1'b0, 1'b0);
      check("reset_const", {front, turn}, 2'b10);
      step("search0", 1'b0, 1'b0, 1'b0);
      step("search1", 1'b0, 1'b0, 1'b0);
      step("rotate_from_search", 1'b0, 1'b1, 1'b0);
      check("rotate_const", {front, turn}, 2'b01);
      step("rotate_to_search", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("follow", 1'b0, 1'b0, 1'b1);
      check("follow_const", {front, turn}, 2'b10);
      step("front_prio_11", 1'b0, 1'b1, 1'b1);
      step("front_prio_10", 1'b0, 1'b1, 1'b0);
      step("rotate_00", 1'b0, 1'b0, 1'b0);
      // full corner timeout
      step("enter_follow", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < CC; i++) begin
         step("corner_run", 1'b0, 1'b0, 1'b0);
         check("corner_const", {front, turn}, 2'b11);
      end
      step("corner_timeout", 1'b0, 1'b0, 1'b0);
      check("timeout_const", {front, turn}, 2'b10);
      // corner rejoined by the left wall
      step("enter_follow2", 1'b0, 1'b0, 1'b1);
      step("corner1", 1'b0, 1'b0, 1'b0);
      step("corner_rejoin", 1'b0, 1'b0, 1'b1);
      check("rejoin_const", {front, turn}, 2'b10);
      // corner interrupted by an obstacle, then counter must restart fresh
      step("corner2", 1'b0, 1'b0, 1'b0);
      step("corner3", 1'b0, 1'b0, 1'b0);
      step("corner_obstacle", 1'b0, 1'b1, 1'b0);
      step("rot_follow", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < CC + 1; i++) step("corner_fresh", 1'b0, 1'b0, 1'b0);
      check("fresh_timeout_const", {front, turn}, 2'b10);
      // reset overrides sensors while rotating
      step("to_rotate", 1'b0, 1'b1, 1'b1);
      step("reset_in_rotate", 1'b1, 1'b1, 1'b1);
      check("reset_override_const", {front, turn}, 2'b10);
`ifdef ROBOT_STATE_OUT_EN
      check("reset_state_const", state_o, 2'd0);
`endif
      // randomized blocks with varying left-wall density
      for (int b = 0; b < 40; b++) begin
         pl = $urandom_range(0, 100);
         for (int i = 0; i < 25; i++) begin
            step("random",
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 99) < pl));
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
